sample_ring_buffer: RTL and testbench
=====================================

Name: sample_ring_buffer

Overview:
- Parametrised circular sample buffer built on an inferred single-clock block RAM; successor to the plain addressed BRAM used in the audio path.
- Adds pointer management, valid/ready streaming on both sides, occupancy/overflow status, and a loop-playback mode that replays captured drum samples indefinitely without consuming them.
- Sits between the sample capture/decimation stage and the audio output/mixer.

Parameters:
- LOGSIZE, 14, log2 of storage depth; DEPTH = 2**LOGSIZE entries.
- WIDTH, 8, sample width in bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush; highest priority
- loop_mode  in  1  0 = FIFO, 1 = loop playback
- wr_valid  in  1  write sample present
- wr_data  in  WIDTH  write sample
- wr_ready  out  1  buffer accepts write
- rd_valid  out  1  output sample valid
- rd_data  out  WIDTH  output sample (registered)
- rd_ready  in  1  consumer accepts sample
- count  out  LOGSIZE+1  stored samples, including any held in the read pipeline
- overflow  out  1  sticky: write attempted while not ready

Behaviour:
- Reset (async, rst_n=0):
  - Pointers, count, overflow, rd_valid and rd_data are 0.
  - FSM is in FIFO.
  - RAM contents are undefined and are not cleared.
- Memory: one port, 1-cycle registered read; at most one RAM write or one RAM read per cycle. Write wins the port; a prefetch read stalls that cycle.
- Pointers:
  - head = oldest unconsumed sample.
  - tail = next write address.
  - rptr = next prefetch address.
  - All pointers are LOGSIZE bits and wrap modulo DEPTH.
- Read pipeline:
  - Stage P is the RAM read in flight; stage O is the output register.
  - A read is issued when rptr != tail (FIFO) and the slot is free: out_valid=0, or P will move into O this cycle.
  - A handshake is rd_valid & rd_ready.
- Latency: a write into an empty buffer gives rd_valid=1 two cycles later at the earliest.
- FSM FIFO state:
  - wr_ready = (count < DEPTH) and no clear.
  - A write handshake writes mem[tail] and increments tail.
  - A read handshake increments head.
  - count is +1, -1, or unchanged; a simultaneous write and read leaves it unchanged.
  - Full: count == DEPTH. Empty: count == 0 and rd_valid=0.
- FIFO → LOOP, on loop_mode rising while in FIFO:
  - Flush P and O (rd_valid=0 next cycle).
  - rptr ← head.
  - Latch loop_len ← count. No sample is consumed.
- FSM LOOP state:
  - wr_ready = 0.
  - Reads issue from rptr; after address head+loop_len-1, rptr wraps to head.
  - Handshakes do not change head or count.
  - loop_len = 0 gives rd_valid held at 0.
  - rd_ready=0 stalls the output in place.
- LOOP → FIFO, on loop_mode falling: the buffer is emptied as if by clear, including overflow.
- clear: same cycle, acts as if reset except for RAM contents; it overrides any concurrent write or read.
- overflow: set on wr_valid & !wr_ready in FIFO state (the sample is dropped); cleared only by reset or clear. Writes in LOOP are ignored and do not set it.
- Stability: rd_data must not change while rd_valid & !rd_ready.

Decomposition:
- Shared package holds:
  - FSM state enum: ST_FIFO, ST_LOOP.
  - A depth-function macro for 2**LOGSIZE.
- One sub-module, sample_ram: a single-port inferred block RAM with parameters LOGSIZE and WIDTH, write enable, and 1-cycle registered read.
- Pointer, count and FSM logic live in the top module.

Test Plan:
- Reset, then write 0x11,0x22,0x33 with rd_ready=1 → rd_data 0x11,0x22,0x33 in order; first rd_valid 2 cycles after the first write; count returns to 0.
- LOGSIZE=3: write 8 samples with rd_ready=0 → wr_ready=0 and count=8. A 9th wr_valid → overflow=1, the data is dropped, and the 8 original samples drain intact.
- Write 5 samples, rd_ready=0, assert loop_mode → output sequence s0..s4,s0..s4,… for 3 loops; count stays 5; wr_valid is ignored.
- Loop with rd_ready toggling every other cycle → no sample skipped or duplicated, and rd_data holds during stalls.
- During loop, deassert loop_mode → count=0, rd_valid=0, overflow=0. A new write 0xAA then appears as the next output.
- Pulse rst_n low mid-stream, asynchronously and off a clock edge → outputs go to 0 immediately. Then pulse clear during simultaneous read and write → count=0 on the next cycle.

Source files
------------

// File: rtl/sample_ring_buffer_pkg.sv
// Shared definitions for the sample ring buffer: storage depth helper and
// the FIFO / loop-playback state encoding.

`ifndef SRB_DEPTH
`define SRB_DEPTH(logsize) (1 << (logsize))
`endif

package sample_ring_buffer_pkg;

  // Operating mode of the buffer: normal streaming FIFO or loop playback
  typedef enum logic {
    ST_FIFO = 1'b0,
    ST_LOOP = 1'b1
  } srb_state_t;

endpackage

// File: rtl/sample_ring_buffer_ram.sv
// Single-port inferred block RAM with a registered read port.
// A write takes the port for the cycle; the read register keeps its last
// value whenever no read is issued, so downstream logic can park data here.

module sample_ram
  import sample_ring_buffer_pkg::*;
#(
  parameter int LOGSIZE = 14,
  parameter int WIDTH   = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [LOGSIZE-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  localparam int DEPTH = `SRB_DEPTH(LOGSIZE);

  logic [WIDTH-1:0] mem [DEPTH];

  // One access per cycle: write has priority, otherwise an optional read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sample_ring_buffer.sv
// Circular sample buffer between capture/decimation and the audio mixer.
// FIFO mode streams samples through a single-port RAM with a two-stage read
// pipeline (P = RAM read in flight, O = output register). Loop mode replays
// the captured window [head, head+loop_len) forever without consuming it.

module sample_ring_buffer
  import sample_ring_buffer_pkg::*;
#(
  parameter int LOGSIZE = 14,
  parameter int WIDTH   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               loop_mode,
  input  logic               wr_valid,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               wr_ready,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               rd_ready,
  output logic [LOGSIZE:0]   count,
  output logic               overflow
);

  localparam int DEPTH = `SRB_DEPTH(LOGSIZE);
  localparam logic [LOGSIZE:0]   FULL_COUNT = (LOGSIZE+1)'(DEPTH);
  localparam logic [LOGSIZE-1:0] PTR_ONE    = LOGSIZE'(1);
  localparam logic [LOGSIZE:0]   CNT_ONE    = (LOGSIZE+1)'(1);

  srb_state_t state, state_next;

  logic [LOGSIZE-1:0] head;
  logic [LOGSIZE-1:0] tail;
  logic [LOGSIZE-1:0] rptr;
  logic [LOGSIZE-1:0] loop_last;
  logic [LOGSIZE:0]   loop_len;
  logic [LOGSIZE:0]   unfetched;
  logic               p_valid;
  logic               loop_mode_q;

  logic               enter_loop;
  logic               leave_loop;
  logic               flush_all;
  logic               wr_fire;
  logic               rd_fire;
  logic               p_to_o;
  logic               p_free;
  logic               fetch_avail;
  logic               rd_issue;

  logic               ram_we;
  logic               ram_re;
  logic [LOGSIZE-1:0] ram_addr;
  logic [WIDTH-1:0]   ram_rdata;

  sample_ram #(
    .LOGSIZE (LOGSIZE),
    .WIDTH   (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  // Mode FSM: enter loop on a rising loop_mode, leave as soon as it drops
  always_comb begin
    state_next = state;
    enter_loop = 1'b0;
    leave_loop = 1'b0;
    wr_ready   = 1'b0;
    case (state)
      ST_FIFO: begin
        wr_ready = (count < FULL_COUNT) && !clear;
        if (loop_mode && !loop_mode_q) begin
          enter_loop = 1'b1;
          state_next = ST_LOOP;
        end
      end
      ST_LOOP: begin
        if (!loop_mode) begin
          leave_loop = 1'b1;
          state_next = ST_FIFO;
        end
      end
      default: state_next = ST_FIFO;
    endcase
    if (clear) begin
      state_next = ST_FIFO;
    end
  end

  // Handshakes, read-pipeline flow control and RAM port arbitration
  always_comb begin
    flush_all = clear || leave_loop;
    wr_fire   = wr_valid && wr_ready;
    rd_fire   = rd_valid && rd_ready;
    p_to_o    = p_valid && (!rd_valid || rd_fire);
    p_free    = !p_valid || p_to_o;
    // Samples stored but not yet prefetched; counting avoids the
    // rptr == tail ambiguity when the buffer is completely full.
    unfetched = count - (LOGSIZE+1)'(p_valid) - (LOGSIZE+1)'(rd_valid);
    loop_last = head + loop_len[LOGSIZE-1:0] - PTR_ONE;
    if (state == ST_LOOP) begin
      fetch_avail = (loop_len != '0);
    end else begin
      fetch_avail = (unfetched != '0);
    end
    rd_issue = fetch_avail && p_free && !wr_fire && !flush_all && !enter_loop;
    ram_we   = wr_fire;
    ram_re   = rd_issue;
    ram_addr = wr_fire ? tail : rptr;
  end

  // Mode state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FIFO;
    end else begin
      state <= state_next;
    end
  end

  // Previous loop_mode for edge detection; a clear while loop_mode is held
  // high therefore does not immediately re-enter loop playback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_mode_q <= 1'b0;
    end else begin
      loop_mode_q <= loop_mode;
    end
  end

  // Pointers, occupancy and the captured loop window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      rptr     <= '0;
      count    <= '0;
      loop_len <= '0;
    end else if (flush_all) begin
      head     <= '0;
      tail     <= '0;
      rptr     <= '0;
      count    <= '0;
      loop_len <= '0;
    end else begin
      if (wr_fire) begin
        tail <= tail + PTR_ONE;
      end
      if (enter_loop) begin
        rptr     <= head;
        loop_len <= count + (LOGSIZE+1)'(wr_fire);
        count    <= count + (LOGSIZE+1)'(wr_fire);
      end else if (state == ST_LOOP) begin
        if (rd_issue) begin
          rptr <= (rptr == loop_last) ? head : rptr + PTR_ONE;
        end
      end else begin
        if (rd_issue) begin
          rptr <= rptr + PTR_ONE;
        end
        if (rd_fire) begin
          head <= head + PTR_ONE;
        end
        if (wr_fire && !rd_fire) begin
          count <= count + CNT_ONE;
        end else if (!wr_fire && rd_fire) begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

  // Read pipeline: P tracks the RAM read in flight, O is the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush_all) begin
      p_valid  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (enter_loop) begin
      p_valid  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (p_to_o) begin
        rd_data  <= ram_rdata;
        rd_valid <= 1'b1;
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
      end
      if (rd_issue) begin
        p_valid <= 1'b1;
      end else if (p_to_o) begin
        p_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow: a FIFO-mode write offered while the buffer refuses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush_all) begin
      overflow <= 1'b0;
    end else if ((state == ST_FIFO) && wr_valid && !wr_ready) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_ring_buffer.sv
// Scoreboard bench for sample_ring_buffer (LOGSIZE=3 so full/wrap are reachable).
// The stimulus side keeps a queue model of stored samples and pushes expected
// outputs; an independent monitor pops and compares on every output handshake.

module tb_sample_ring_buffer;

  localparam int LOGSIZE = 3;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 1 << LOGSIZE;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic               loop_mode;
  logic               wr_valid;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_ready;
  logic               rd_valid;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_ready;
  logic [LOGSIZE:0]   count;
  logic               overflow;

  logic [WIDTH-1:0]   exp_q[$];
  logic [WIDTH-1:0]   loop_seq[$];
  int                 compared   = 0;
  int                 mismatched = 0;
  logic               in_loop    = 1'b0;
  logic               ovf_m      = 1'b0;
  logic               lm_prev    = 1'b0;
  logic               chk_hold   = 1'b0;
  logic               prev_stall = 1'b0;
  logic [WIDTH-1:0]   prev_data  = '0;

  sample_ring_buffer #(
    .LOGSIZE (LOGSIZE),
    .WIDTH   (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .loop_mode (loop_mode),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the bench
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Append the captured loop window reps times to the expected stream
  task automatic refillLoop(input int reps);
    for (int r = 0; r < reps; r++) begin
      foreach (loop_seq[k]) exp_q.push_back(loop_seq[k]);
    end
  endtask

  // One clock of stimulus, called at posedge+1; updates the model and checks status
  task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic rr,
                               input logic lm, input logic clr);
    logic can_write;
    logic accept;
    wr_valid  = wv;
    wr_data   = wd;
    rd_ready  = rr;
    loop_mode = lm;
    clear     = clr;
    can_write = !clr && !in_loop && (exp_q.size() < DEPTH);
    accept    = wv && can_write;
    #1;
    checkOutput("wr_ready", wr_ready, can_write);
    if (accept) exp_q.push_back(wd);
    if (wv && !clr && !in_loop && !accept) ovf_m = 1'b1;
    @(posedge clk);
    #1;
    if (clr || (in_loop && !lm)) begin
      exp_q.delete();
      ovf_m   = 1'b0;
      in_loop = 1'b0;
    end else if (!in_loop && lm && !lm_prev) begin
      loop_seq = exp_q;
      exp_q.delete();
      in_loop = 1'b1;
    end
    lm_prev = lm;
    checkOutput("count", count, in_loop ? loop_seq.size() : exp_q.size());
    checkOutput("overflow", overflow, ovf_m);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rr, in_loop, 1'b0);
  endtask

  // Run loop playback until the expected stream is consumed (bounded)
  task automatic runLoopPhase(input logic toggle, input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      applyStimulus(1'b1, WIDTH'($urandom), toggle ? logic'(n % 2) : 1'b1, 1'b1, 1'b0);
      n++;
    end
    checkOutput("loop_phase_done", exp_q.size(), 0);
  endtask

  // Monitor: compare every output handshake and output stability during stalls
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (chk_hold && prev_stall) begin
          checkOutput("hold_valid", rd_valid, 1);
          checkOutput("hold_data", rd_data, prev_data);
        end
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_output: actual=0x%0h required=none at %0t", rd_data, $time);
          end else begin
            e = exp_q.pop_front();
            checkOutput("rd_data", rd_data, e);
          end
        end
        prev_stall = rd_valid && !rd_ready;
        prev_data  = rd_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    loop_mode = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    #2;
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic ordering and latency");
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("latency_one_edge", rd_valid, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("latency_two_edges", rd_valid, 1);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);
    checkOutput("basic_drain", exp_q.size(), 0);
    checkOutput("basic_count_zero", count, 0);

    $display("[TB] full and overflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", count, DEPTH);
    checkOutput("full_wr_ready", wr_ready, 0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow_set", overflow, 1);
    idle(3, 1'b0);
    idle(30, 1'b1);
    checkOutput("overflow_drain", exp_q.size(), 0);
    checkOutput("overflow_sticky", overflow, 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_overflow", overflow, 0);

    $display("[TB] loop playback");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("loop_entry_flush", rd_valid, 0);
    refillLoop(3);
    runLoopPhase(1'b0, 100);
    checkOutput("loop_count", count, 5);
    refillLoop(2);
    chk_hold = 1'b1;
    runLoopPhase(1'b1, 100);
    chk_hold = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("loop_exit_valid", rd_valid, 0);
    checkOutput("loop_exit_count", count, 0);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);
    checkOutput("post_loop_drain", exp_q.size(), 0);

    $display("[TB] random streaming");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(logic'($urandom_range(0, 9) < 6), WIDTH'($urandom),
                    logic'($urandom_range(0, 1)), 1'b0, logic'($urandom_range(0, 63) == 0));
    end
    idle(20, 1'b1);
    checkOutput("random_drain", exp_q.size(), 0);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("pre_reset_valid", rd_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rd_valid", rd_valid, 0);
    checkOutput("async_rd_data", rd_data, 0);
    checkOutput("async_count", count, 0);
    exp_q.delete();
    ovf_m   = 1'b0;
    in_loop = 1'b0;
    lm_prev = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] clear during simultaneous read and write");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    checkOutput("clear_count", count, 0);
    checkOutput("clear_rd_valid", rd_valid, 0);
    idle(5, 1'b1);
    checkOutput("clear_nothing_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
